traffic_log_reader: RTL and testbench
=====================================

# traffic_log_reader

Read-side initiator for the Intersection traffic-count memory. On request, it sweeps a range of addresses and reads the stored 4-bit count for both streets at each address. It accumulates per-street totals, tracks the peak single count, and reports which street is busier. It drives the same memory port signals (read_Write, memory_Enable, address, street) that the Intersection memory responds to, and consumes the Intersection's traffic_Street read data.

## Interface
Parameters:
- ADDR_WIDTH, 7, memory address width; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 4, width of one stored traffic count.
- SUM_WIDTH, ADDR_WIDTH+DATA_WIDTH (11), width of each total; a full sweep cannot overflow it.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request a sweep; sampled only in IDLE.
- first_Address  in  ADDR_WIDTH  first address of the sweep; sampled with start.
- last_Address  in  ADDR_WIDTH  last address, inclusive; sampled with start.
- read_Write  out  1  memory direction; tied 0 (read).
- memory_Enable  out  1  memory read strobe.
- address  out  ADDR_WIDTH  memory address.
- street  out  1  street select: 0 = street 0, 1 = street 1.
- traffic_Street  in  DATA_WIDTH  memory read data, valid the cycle after memory_Enable.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when results become valid.
- total_Street_0  out  SUM_WIDTH  sum of street-0 counts.
- total_Street_1  out  SUM_WIDTH  sum of street-1 counts.
- busier_Street  out  1  1 only if total_Street_1 > total_Street_0.
- peak_Value  out  DATA_WIDTH  largest count seen in the sweep.
- peak_Address  out  ADDR_WIDTH  address where peak_Value was first seen.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE: when start=1, latch the range, set the address counter to first_Address and street to 0, clear totals and peak, go to ISSUE.
- ISSUE: assert memory_Enable=1 with the current address and street, go to CAPTURE.
- CAPTURE: memory_Enable=0. Add traffic_Street to the total selected by street.
  - Update the peak only if traffic_Street > peak_Value (strict), so ties keep the earlier address.
  - If street=0: set street to 1, go to ISSUE.
  - Else if address = latched last: go to DONE.
  - Else: increment the address modulo 2**ADDR_WIDTH, set street to 0, go to ISSUE.
- DONE: done=1, update busier_Street, go to IDLE.
- Wrap-around: if last < first, the sweep runs first, ..., max, 0, ..., last. Number of addresses N = ((last − first) mod 2**ADDR_WIDTH) + 1. first = last reads exactly one address.
- busier_Street: 0 on a tie.
- start is ignored while busy=1 and during DONE.
- Results hold their values from DONE until the next accepted start.

## Timing
- Reset values (reset_n=0 at a clock edge): state IDLE; all outputs 0, including every total, peak_Value, peak_Address, busier_Street, address and street.
- Reset mid-sweep: abort on the next edge and return to reset values. No partial results are retained.
- A sweep accepted at edge 0 runs ISSUE/CAPTURE pairs in cycles 1..4N. DONE (done=1) is cycle 4N+1. IDLE resumes at cycle 4N+2.
- busy=1 in cycles 1..4N+1.
- memory_Enable is high only in ISSUE cycles: cycles 1, 3, 5, ... (2N pulses total).
- traffic_Street is sampled at the edge that ends each CAPTURE cycle.
- Back-to-back: a start asserted in the cycle after DONE is accepted.

## Configuration
- TRAFFIC_LOG_PEAK_EN defined: peak tracking logic is present, and peak_Value and peak_Address behave as above.
- TRAFFIC_LOG_PEAK_EN undefined: no peak comparator or registers are built. peak_Value and peak_Address are constant 0. All other behaviour and timing are unchanged.

## Structure
- Shared package traffic_pkg holds:
  - the FSM state typedef (IDLE, ISSUE, CAPTURE, DONE);
  - ADDR_WIDTH and DATA_WIDTH defaults;
  - STREET_0/STREET_1 constants;
  - the read_Write encoding constants (READ=0, WRITE=1).
- One natural sub-module, traffic_accumulator:
  - holds both totals and the peak registers (the latter under TRAFFIC_LOG_PEAK_EN);
  - inputs: clear, capture strobe, street, data, address.
- Top level keeps the FSM, address counter and port drive.

## Test plan
- Single-address sweep: memory at address 5 holds street0=3, street1=9; first=last=5 → 2 memory_Enable pulses, done at cycle 5, totals 3/9, busier_Street=1, peak 9 at address 5.
- Range with tie: addresses 0..3 all hold 15/15 → done at cycle 17, totals 60/60, busier_Street=0, peak 15 at address 0 (first occurrence kept).
- Wrap-around: first=126, last=1 → addresses read in order 126, 127, 0, 1; done at cycle 17; address never leaves that set.
- Full-depth sweep: first=0, last=127, all cells hold 15 → totals 1920 each with no overflow, done at cycle 513.
- Reset mid-sweep: reset_n=0 at cycle 6 → next cycle busy=0, done never pulses, all outputs 0. A start after reset completes normally.
- start while busy: a second start at cycle 3 with a different range is ignored, and results match the first range. Also rerun without TRAFFIC_LOG_PEAK_EN: peak outputs stay 0 and totals are unchanged.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the Intersection traffic-count reader.
// Holds the reader FSM state type, default widths and memory port encodings.
package traffic_pkg;

    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_DATA_WIDTH = 4;

    localparam logic STREET_0 = 1'b0;
    localparam logic STREET_1 = 1'b1;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/traffic_accumulator.sv
// Per-street running totals plus optional peak tracking for the traffic log reader.
// Peak registers exist only when TRAFFIC_LOG_PEAK_EN is defined; otherwise the peak outputs are constant 0.
module traffic_accumulator
    import traffic_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SUM_WIDTH  = ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  capture,
    input  logic                  street,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [SUM_WIDTH-1:0]  total_0,
    output logic [SUM_WIDTH-1:0]  total_1,
    output logic [DATA_WIDTH-1:0] peak_value,
    output logic [ADDR_WIDTH-1:0] peak_address
);

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            total_0 <= '0;
            total_1 <= '0;
        end else if (capture) begin
            if (street == STREET_0) begin
                total_0 <= total_0 + SUM_WIDTH'(data);
            end else begin
                total_1 <= total_1 + SUM_WIDTH'(data);
            end
        end
    end

`ifdef TRAFFIC_LOG_PEAK_EN
    // Strict compare so a tie keeps the address where the value first appeared.
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            peak_value   <= '0;
            peak_address <= '0;
        end else if (capture && (data > peak_value)) begin
            peak_value   <= data;
            peak_address <= address;
        end
    end
`else
    logic unused_address;

    assign unused_address = ^address;
    assign peak_value     = '0;
    assign peak_address   = '0;
`endif

endmodule

// File: rtl/traffic_log_reader.sv
// Read-side sweeper for the Intersection traffic-count memory: reads both streets over an address range.
// Optional peak tracking is enabled by defining TRAFFIC_LOG_PEAK_EN.
module traffic_log_reader
    import traffic_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SUM_WIDTH  = ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_Address,
    input  logic [ADDR_WIDTH-1:0] last_Address,
    output logic                  read_Write,
    output logic                  memory_Enable,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  street,
    input  logic [DATA_WIDTH-1:0] traffic_Street,
    output logic                  busy,
    output logic                  done,
    output logic [SUM_WIDTH-1:0]  total_Street_0,
    output logic [SUM_WIDTH-1:0]  total_Street_1,
    output logic                  busier_Street,
    output logic [DATA_WIDTH-1:0] peak_Value,
    output logic [ADDR_WIDTH-1:0] peak_Address
);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   last_addr;
    logic                    clear_acc;
    logic                    capture_acc;

    assign read_Write  = READ;
    assign clear_acc   = (state == IDLE) && start;
    assign capture_acc = (state == CAPTURE);

    // memory_Enable and done are set on the transition into ISSUE/DONE so they are clean registered strobes.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            last_addr     <= '0;
            address       <= '0;
            street        <= STREET_0;
            memory_Enable <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            busier_Street <= 1'b0;
        end else begin
            memory_Enable <= 1'b0;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        last_addr     <= last_Address;
                        address       <= first_Address;
                        street        <= STREET_0;
                        busier_Street <= 1'b0;
                        busy          <= 1'b1;
                        memory_Enable <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (street == STREET_0) begin
                        street        <= STREET_1;
                        memory_Enable <= 1'b1;
                        state         <= ISSUE;
                    end else if (address == last_addr) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        address       <= address + ADDR_WIDTH'(1);
                        street        <= STREET_0;
                        memory_Enable <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                DONE: begin
                    busier_Street <= (total_Street_1 > total_Street_0);
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    traffic_accumulator #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .SUM_WIDTH (SUM_WIDTH)
    ) u_accumulator (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (clear_acc),
        .capture     (capture_acc),
        .street      (street),
        .data        (traffic_Street),
        .address     (address),
        .total_0     (total_Street_0),
        .total_1     (total_Street_1),
        .peak_value  (peak_Value),
        .peak_address(peak_Address)
    );

endmodule

// File: tb/tb_traffic_log_reader.sv
// Directed self-checking bench for traffic_log_reader with a two-street memory model.
// Peak expectations follow TRAFFIC_LOG_PEAK_EN: zero when the macro is undefined.
module tb_traffic_log_reader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [6:0]  first_Address;
    logic [6:0]  last_Address;
    logic        read_Write;
    logic        memory_Enable;
    logic [6:0]  address;
    logic        street;
    logic [3:0]  traffic_Street = 4'd0;
    logic        busy;
    logic        done;
    logic [10:0] total_Street_0;
    logic [10:0] total_Street_1;
    logic        busier_Street;
    logic [3:0]  peak_Value;
    logic [6:0]  peak_Address;

    logic [3:0]  mem0 [128];
    logic [3:0]  mem1 [128];

    int checks = 0;
    int passed = 0;

    int done_cycle;
    int pulses;
    int done_count;
    int seq_err;
    logic busy_first;
    logic busy_at_done;
    logic busy_after;
    logic done_after;

    always #5 clock = ~clock;

    traffic_log_reader dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .first_Address (first_Address),
        .last_Address  (last_Address),
        .read_Write    (read_Write),
        .memory_Enable (memory_Enable),
        .address       (address),
        .street        (street),
        .traffic_Street(traffic_Street),
        .busy          (busy),
        .done          (done),
        .total_Street_0(total_Street_0),
        .total_Street_1(total_Street_1),
        .busier_Street (busier_Street),
        .peak_Value    (peak_Value),
        .peak_Address  (peak_Address)
    );

    // Memory answers one cycle after the enable strobe.
    always @(posedge clock) begin
        if (memory_Enable) begin
            traffic_Street <= street ? mem1[address] : mem0[address];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clearMem();
        for (int i = 0; i < 128; i++) begin
            mem0[i] = 4'd0;
            mem1[i] = 4'd0;
        end
    endtask

    // Called at a negedge; start is seen at the next edge (edge 0), so sweeps chain back-to-back.
    task automatic applyStimulus(input logic [6:0] f, input logic [6:0] l, input int n,
                                 input int inject_cycle, input logic [6:0] f2, input logic [6:0] l2);
        int cyc;
        int idx;
        logic [6:0] exp_a;
        logic exp_s;
        start = 1'b1;
        first_Address = f;
        last_Address = l;
        @(posedge clock);
        cyc = 0;
        idx = 0;
        pulses = 0;
        done_cycle = -1;
        done_count = 0;
        seq_err = 0;
        busy_first = 1'b0;
        busy_at_done = 1'b0;
        busy_after = 1'b1;
        done_after = 1'b1;
        while (cyc < 4 * n + 20) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (cyc == inject_cycle) begin
                start = 1'b1;
                first_Address = f2;
                last_Address = l2;
            end
            if (cyc == inject_cycle + 1) start = 1'b0;
            if (memory_Enable) begin
                exp_a = f + 7'(idx / 2);
                exp_s = idx[0];
                if (address !== exp_a || street !== exp_s) seq_err++;
                pulses++;
                idx++;
            end
            if (cyc == 1) busy_first = busy;
            if (done) begin
                done_count++;
                if (done_cycle < 0) begin
                    done_cycle = cyc;
                    busy_at_done = busy;
                end
            end
            if (done_cycle > 0 && cyc == done_cycle + 1) begin
                busy_after = busy;
                done_after = done;
                break;
            end
        end
    endtask

    task automatic checkSweep(input string name, input int n, input int t0, input int t1,
                              input int bz, input int pk, input int pka);
        checkOutput({name, "_done_count"}, done_count, 1);
        checkOutput({name, "_done_cycle"}, done_cycle, 4 * n + 1);
        checkOutput({name, "_enable_pulses"}, pulses, 2 * n);
        checkOutput({name, "_addr_sequence_errors"}, seq_err, 0);
        checkOutput({name, "_busy_cycle1"}, busy_first, 1);
        checkOutput({name, "_busy_at_done"}, busy_at_done, 1);
        checkOutput({name, "_busy_after_done"}, busy_after, 0);
        checkOutput({name, "_done_single_pulse"}, done_after, 0);
        checkOutput({name, "_total0"}, total_Street_0, t0);
        checkOutput({name, "_total1"}, total_Street_1, t1);
        checkOutput({name, "_busier"}, busier_Street, bz);
        checkOutput({name, "_read_write"}, read_Write, 0);
`ifdef TRAFFIC_LOG_PEAK_EN
        checkOutput({name, "_peak_value"}, peak_Value, pk);
        checkOutput({name, "_peak_address"}, peak_Address, pka);
`else
        checkOutput({name, "_peak_value"}, peak_Value, 0);
        checkOutput({name, "_peak_address"}, peak_Address, 0);
        if (pk < 0 || pka < 0) $display("[TB] unexpected negative peak expectation");
`endif
    endtask

    initial begin
        int dcount;
        reset_n = 1'b0;
        start = 1'b0;
        first_Address = 7'd0;
        last_Address = 7'd0;
        clearMem();
        repeat (3) @(negedge clock);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_mem_enable", memory_Enable, 0);
        checkOutput("reset_address", address, 0);
        checkOutput("reset_totals", {total_Street_0, total_Street_1}, 0);
        checkOutput("reset_peak", {peak_Value, peak_Address, busier_Street}, 0);
        reset_n = 1'b1;
        @(negedge clock);

        $display("[TB] single-address sweep");
        mem0[5] = 4'd3;
        mem1[5] = 4'd9;
        applyStimulus(7'd5, 7'd5, 1, 0, 7'd0, 7'd0);
        checkSweep("single", 1, 3, 9, 1, 9, 5);

        $display("[TB] tie range 0..3");
        clearMem();
        for (int i = 0; i < 4; i++) begin
            mem0[i] = 4'd15;
            mem1[i] = 4'd15;
        end
        applyStimulus(7'd0, 7'd3, 4, 0, 7'd0, 7'd0);
        checkSweep("tie", 4, 60, 60, 0, 15, 0);

        $display("[TB] wrap-around 126..1");
        clearMem();
        mem0[126] = 4'd1; mem1[126] = 4'd2;
        mem0[127] = 4'd4; mem1[127] = 4'd3;
        mem0[0]   = 4'd5; mem1[0]   = 4'd6;
        mem0[1]   = 4'd7; mem1[1]   = 4'd8;
        applyStimulus(7'd126, 7'd1, 4, 0, 7'd0, 7'd0);
        checkSweep("wrap", 4, 17, 19, 1, 8, 1);

        $display("[TB] start while busy");
        clearMem();
        mem0[0] = 4'd2; mem1[0] = 4'd1;
        mem0[1] = 4'd6; mem1[1] = 4'd3;
        for (int i = 10; i <= 12; i++) begin
            mem0[i] = 4'd9;
            mem1[i] = 4'd9;
        end
        applyStimulus(7'd0, 7'd1, 2, 3, 7'd10, 7'd12);
        checkSweep("ignore_start", 2, 8, 4, 0, 6, 1);

        $display("[TB] full-depth sweep");
        for (int i = 0; i < 128; i++) begin
            mem0[i] = 4'd15;
            mem1[i] = 4'd15;
        end
        applyStimulus(7'd0, 7'd127, 128, 0, 7'd0, 7'd0);
        checkSweep("full", 128, 1920, 1920, 0, 15, 0);

        $display("[TB] reset mid-sweep");
        clearMem();
        for (int i = 0; i < 4; i++) begin
            mem0[i] = 4'd15;
            mem1[i] = 4'd15;
        end
        start = 1'b1;
        first_Address = 7'd0;
        last_Address = 7'd3;
        @(posedge clock);
        dcount = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            if (c == 1) start = 1'b0;
            if (done) dcount++;
        end
        checkOutput("midreset_partial_total0", total_Street_0, 15);
        checkOutput("midreset_partial_total1", total_Street_1, 15);
        reset_n = 1'b0;
        @(negedge clock);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_done", done, 0);
        checkOutput("midreset_totals", {total_Street_0, total_Street_1}, 0);
        checkOutput("midreset_addr_street_en", {address, street, memory_Enable}, 0);
        checkOutput("midreset_peak_busier", {peak_Value, peak_Address, busier_Street}, 0);
        reset_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (done) dcount++;
        end
        checkOutput("midreset_no_done", dcount, 0);
        checkOutput("midreset_idle_busy", busy, 0);
        applyStimulus(7'd0, 7'd3, 4, 0, 7'd0, 7'd0);
        checkSweep("after_reset", 4, 60, 60, 0, 15, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
